// File: rtl/data_ram_arbiter.sv
// Two-master arbiter sharing the data RAM port; the owner passes straight through.
// Define DATA_ARB_ROUND_ROBIN_EN for burst-limited round-robin, else m0 has fixed priority.
module data_ram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ce_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_stall_o,
  input  logic              m1_ce_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_stall_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              owner_o
);

  if (MAX_BURST < 2) begin : g_bad_burst
    $error("MAX_BURST must be at least 2");
  end

  logic              owner_q;
  logic              owner_d;
  logic              o_ce;
  logic              o_we;
  logic              x_ce;
  logic [ADDR_W-1:0] o_addr;
  logic [3:0]        o_sel;
  logic [DATA_W-1:0] o_wdata;
  logic              pass;

  always_comb begin
    if (owner_q) begin
      o_ce    = m1_ce_i;
      o_we    = m1_we_i;
      o_addr  = m1_addr_i;
      o_sel   = m1_sel_i;
      o_wdata = m1_data_i;
      x_ce    = m0_ce_i;
    end else begin
      o_ce    = m0_ce_i;
      o_we    = m0_we_i;
      o_addr  = m0_addr_i;
      o_sel   = m0_sel_i;
      o_wdata = m0_data_i;
      x_ce    = m1_ce_i;
    end
  end

  // Reset blanks every output so an abandoned burst cannot write.
  assign pass       = ~rst & o_ce;
  assign ram_ce_o   = pass;
  assign ram_we_o   = pass & o_we;
  assign ram_addr_o = pass ? o_addr  : '0;
  assign ram_sel_o  = pass ? o_sel   : '0;
  assign ram_data_o = pass ? o_wdata : '0;
  assign m0_data_o  = (~rst & ~owner_q) ? ram_data_i : '0;
  assign m1_data_o  = (~rst &  owner_q) ? ram_data_i : '0;
  assign m0_stall_o = ~rst & m0_ce_i &  owner_q;
  assign m1_stall_o = ~rst & m1_ce_i & ~owner_q;
  assign owner_o    = ~rst & owner_q;

`ifdef DATA_ARB_ROUND_ROBIN_EN
  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    owner_d = owner_q;
    cnt_d   = '0;
    if (x_ce) begin
      if (!o_ce || cnt_q == LAST) begin
        owner_d = ~owner_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_x_ce;
  assign unused_x_ce = x_ce;

  always_comb begin
    owner_d = owner_q;
    if (m0_ce_i) begin
      owner_d = 1'b0;
    end else if (m1_ce_i) begin
      owner_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
    end
  end
`endif

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-master arbiter that shares the single data RAM port of the minimal SOPC between the CPU data port (master 0) and a second bus master (master 1: DMA/loader/debug). It sits between the masters and `data_ram`. It tracks the current owner, routes the owner's access straight through in the same cycle and stalls the other master. Ownership changes only on a clock edge, under a burst limit (round-robin build) or a fixed-priority rule.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_BURST`, 8, max consecutive owned access cycles while the other master waits (≥2)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `m0_ce_i` / `m1_ce_i`  in  1  master access request (held until the master's stall is low)
- `m0_we_i` / `m1_we_i`  in  1  write enable
- `m0_addr_i` / `m1_addr_i`  in  ADDR_W  byte address
- `m0_sel_i` / `m1_sel_i`  in  4  byte lane select
- `m0_data_i` / `m1_data_i`  in  DATA_W  write data
- `m0_data_o` / `m1_data_o`  out  DATA_W  read data; 0 when not owner
- `m0_stall_o` / `m1_stall_o`  out  1  request pending but not owner; master must hold its request stable
- `ram_ce_o`, `ram_we_o`  out  1  to data_ram
- `ram_addr_o`  out  ADDR_W;  `ram_sel_o`  out  4;  `ram_data_o`  out  DATA_W;  `ram_data_i`  in  DATA_W
- `owner_o`  out  1  current owner (0 = m0, 1 = m1), status/debug

## Operation
- State: `owner` register (1 bit) and `burst_cnt` register ($clog2(MAX_BURST) bits).
- Datapath is combinational from `owner`:
  - `ram_ce_o` = ce of owner.
  - `ram_we_o` = owner we & owner ce.
  - `ram_addr_o`, `ram_sel_o` and `ram_data_o` come from the owner when its ce is high, else 0.
  - `mN_data_o` = `ram_data_i` if N is the owner, else 0.
  - `mN_stall_o` = `mN_ce_i` & (owner != N).
- The owner stays parked after its accesses end: an idle bus keeps the last owner.
- Next-owner rule, evaluated each edge (O = owner, X = other):
  - X ce low: O stays; `burst_cnt` <= 0.
  - X ce high, O ce low: switch to X; `burst_cnt` <= 0.
  - X ce high, O ce high, `burst_cnt` == MAX_BURST-1: switch to X; `burst_cnt` <= 0.
  - X ce high, O ce high, otherwise: stay; `burst_cnt` <= `burst_cnt` + 1.
- `burst_cnt` never wraps. It saturates at the switch point by construction.
- Writes reach RAM only from the owner. A stalled write never reaches `ram_we_o`.
- Both masters idle: no change. Both request in the parked-owner cycle: the parked owner is served.

## Timing
- Reset (`rst` high at an edge): `owner` <= 0, `burst_cnt` <= 0.
- While `rst` is high, all outputs are forced to 0, including the stalls and `ram_we_o`. An in-progress burst is abandoned, with no partial write beyond the current edge.
- Owner access: zero added latency. Address and data go through in the same cycle, the RAM writes at the next edge, and read data returns in the same cycle as data_ram's combinational read.
- Non-owner request while the owner is idle: exactly 1 stall cycle, then it is served.
- Round-robin worst-case wait for a continuously stalled master: MAX_BURST cycles.
- `owner_o` changes only on rising edges.

## Configuration
- `DATA_ARB_ROUND_ROBIN_EN` defined: the burst-limit rule above applies symmetrically to both masters.
- Not defined: fixed priority, m0 highest, and `burst_cnt` is removed.
  - If m0 ce is high and the owner is 1, switch to m0 at the next edge, even mid-burst of m1.
  - m1 gains ownership only at an edge where m0 ce is low and m1 ce is high.
  - m0 is never stalled more than 1 cycle.

## Test plan
- After reset, m0 reads addr 0x10 with RAM holding 0x12345678 at 0x10: `m0_data_o` = 0x12345678 in the same cycle, `m0_stall_o` = 0, `owner_o` = 0.
- m0 idle, m1 writes 0xDEADBEEF to 0x20 with sel 4'b1111: `m1_stall_o` = 1 for one cycle, then the write passes. A later m0 read of 0x20 returns 0xDEADBEEF after 1 stall cycle.
- Round-robin, MAX_BURST = 8, both ce held high from owner 0: m0 is served 8 cycles, then m1 8 cycles, alternating. `owner_o` toggles every 8 edges, and no stalled write appears on `ram_we_o`.
- Fixed priority, m1 owner mid-burst, m0 asserts ce: m0 is stalled exactly 1 cycle, then owns the bus. m1 stays stalled until m0 ce drops.
- `rst` asserted while m1 owns and writes: all outputs read 0 in the reset cycles. After release, `owner_o` = 0 and `burst_cnt` = 0, and the RAM is unchanged at the abandoned address after the reset edge.
- Both ce low for 5 cycles after m1 ownership: `owner_o` stays 1 and `ram_ce_o` = 0. Then m0 requests: 1 stall cycle, then it is served.
